// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive sequencer: FSM state codes,
// frame-length constants, the shift-register reset value and a frame-length helper.
package rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_e;

    localparam logic [3:0] FRAME_LEN_9  = 4'd9;
    localparam logic [3:0] FRAME_LEN_10 = 4'd10;
    localparam logic [3:0] FRAME_LEN_11 = 4'd11;

    localparam logic [9:0] SR_RESET = 10'h3FF;

    // Total shift count for a frame, start bit included.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        logic [3:0] len;
        case ({eight, pen})
            2'b00:   len = FRAME_LEN_9;
            2'b11:   len = FRAME_LEN_11;
            default: len = FRAME_LEN_10;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time counter for the receive sequencer: free-runs from a synchronous clear
// and flags the half-bit and full-bit points against the programmed baud divisor.
module rx_bit_timer #(
    parameter int CNT_W = 19
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] baud_k_i,
    output logic             mid_o,
    output logic             full_o
);

    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;

    assign tcnt_d = clr_i ? '0 : tcnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign mid_o  = (tcnt_q == (baud_k_i >> 1));
    assign full_o = (tcnt_q == (baud_k_i - 1'b1));

endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: start-bit detect, bit timing, 10-bit right-shift register
// and sticky ready/parity/framing/overrun flags. Define RX_SYNC_EN to add a 2-flop rx synchroniser.
module rx_ctrl
    import rx_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [CNT_W-1:0] baud_k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             clr_rdy,
    output logic [9:0]       sr,
    output logic             rxrdy,
    output logic             perr,
    output logic             ferr,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    rx_state_e  state_q;
    logic [9:0] sr_q;
    logic [9:0] sr_d;
    logic [3:0] bcnt_q;
    logic [3:0] len_q;
    logic       eight_q;
    logic       pen_q;
    logic       ohel_q;
    logic       rxrdy_q;
    logic       perr_q;
    logic       ferr_q;
    logic       ovf_q;

    logic       rx_s;
    logic       mid;
    logic       full;
    logic       shift_en;
    logic       tmr_clr;
    logic       par_odd;
    logic       perr_set;
    logic       perr_keep;
    logic       ferr_keep;
    logic       ovf_keep;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    assign shift_en = ((state_q == ST_START) && mid && !rx_s) ||
                      ((state_q == ST_DATA) && full);

    // The counter sits at zero while the line idles high, so the detect edge is tick 1.
    assign tmr_clr = shift_en ||
                     (state_q == ST_DONE) ||
                     ((state_q == ST_IDLE) && rx_s) ||
                     ((state_q == ST_START) && mid && rx_s);

    rx_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (tmr_clr),
        .baud_k_i(baud_k),
        .mid_o   (mid),
        .full_o  (full)
    );

    assign sr_d = {rx_s, sr_q[9:1]};

    // 7-bit parity frames still carry the start bit in sr[0], 8-bit ones do not.
    assign par_odd   = eight_q ? (^sr_q[8:0]) : (^sr_q[8:1]);
    assign perr_set  = pen_q & (par_odd != ohel_q);
    assign perr_keep = perr_q & ~clr_rdy;
    assign ferr_keep = ferr_q & ~clr_rdy;
    assign ovf_keep  = ovf_q & ~clr_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= SR_RESET;
            bcnt_q  <= 4'd0;
            len_q   <= FRAME_LEN_10;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            rxrdy_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        bcnt_q  <= 4'd0;
                        len_q   <= frame_len(eight, pen);
                        eight_q <= eight;
                        pen_q   <= pen;
                        ohel_q  <= ohel;
                    end
                end
                ST_START: begin
                    if (mid) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            sr_q    <= sr_d;
                            bcnt_q  <= 4'd1;
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (full) begin
                        sr_q   <= sr_d;
                        bcnt_q <= bcnt_q + 4'd1;
                        if (bcnt_q == (len_q - 4'd1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Set terms override a coincident clr_rdy.
                    state_q <= ST_IDLE;
                    rxrdy_q <= 1'b1;
                    ferr_q  <= ferr_keep | ~sr_q[9];
                    perr_q  <= perr_keep | perr_set;
                    ovf_q   <= ovf_keep | rxrdy_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sr        = sr_q;
    assign rxrdy     = rxrdy_q;
    assign perr      = perr_q;
    assign ferr      = ferr_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl: frames are driven serially, expected sr/flags/latency
// are queued at frame start and a monitor compares them once the FSM leaves DONE.
module tb_rx_ctrl;
  import rx_pkg::*;

  localparam int CNT_W = 19;
`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic [CNT_W-1:0] baud_k;
  logic             eight;
  logic             pen;
  logic             ohel;
  logic             clr_rdy;
  logic [9:0]       sr;
  logic             rxrdy;
  logic             perr;
  logic             ferr;
  logic             ovf;
  logic [1:0]       dbg_state;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  // {sr[9:0], rxrdy, perr, ferr, ovf}
  logic [13:0] exp_q[$];
  int          lat_q[$];
  int          start_q[$];

  rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .baud_k   (baud_k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .clr_rdy  (clr_rdy),
    .sr       (sr),
    .rxrdy    (rxrdy),
    .perr     (perr),
    .ferr     (ferr),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d passed=%0d", checks, passes);
    $fatal(1);
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (int'(baud_k)) @(negedge clk);
  endtask

  task automatic set_mode(input logic e, input logic p, input logic o);
    eight = e;
    pen   = p;
    ohel  = o;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int nd, input logic [7:0] data, input logic use_par,
                            input logic pbit, input logic stop, input int gap,
                            input logic flip, input logic [13:0] exp_v);
    int n;
    n = nd + (use_par ? 1 : 0) + 2;
    exp_q.push_back(exp_v);
    lat_q.push_back(int'(baud_k >> 1) + (n - 1) * int'(baud_k) + 1 + SYNC_LAT);
    start_q.push_back(cyc);
    drive_bit(1'b0);
    if (flip) set_mode(~eight, ~pen, ~ohel);
    for (int i = 0; i < nd; i++) drive_bit(data[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(stop);
    if (flip) set_mode(~eight, ~pen, ~ohel);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [1:0]  prev;
    logic [13:0] e;
    int          l;
    int          s;
    prev = 2'(ST_IDLE);
    forever begin
      @(negedge clk);
      if (prev == 2'(ST_DONE)) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: got sr=0x%0h with no frame expected", sr);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          s = start_q.pop_front();
          check("frame_sr", 32'(sr), 32'(e[13:4]));
          check("frame_flags", 32'({rxrdy, perr, ferr, ovf}), 32'(e[3:0]));
          check("frame_latency", 32'(cyc - s - 1), 32'(l));
        end
      end
      prev = dbg_state;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    baud_k  = 19'd16;
    clr_rdy = 1'b0;
    set_mode(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_sr", 32'(sr), 32'h3FF);
    check("reset_flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // 8N1 0xA5
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 48, 1'b0, {10'h34A, 4'b1000});
    pulse_clr();
    // 7E1 0x41, good parity then bad parity
    set_mode(1'b0, 1'b1, 1'b0);
    send_frame(7, 8'h41, 1'b1, 1'b0, 1'b1, 48, 1'b0, {10'h282, 4'b1000});
    pulse_clr();
    send_frame(7, 8'h41, 1'b1, 1'b1, 1'b1, 48, 1'b0, {10'h382, 4'b1100});
    pulse_clr();
    // 8O1 0x3C with odd parity bit; mode inputs toggled mid-frame must be ignored
    set_mode(1'b1, 1'b1, 1'b1);
    send_frame(8, 8'h3C, 1'b1, 1'b1, 1'b1, 48, 1'b1, {10'h33C, 4'b1000});
    pulse_clr();
    // 7N1 0x55: 9 shifts leave the previous stop bit in sr[0]
    set_mode(1'b0, 1'b0, 1'b0);
    send_frame(7, 8'h55, 1'b0, 1'b0, 1'b1, 48, 1'b0, {10'h355, 4'b1000});
    pulse_clr();
    // minimum divisor
    set_mode(1'b1, 1'b0, 1'b0);
    baud_k = 19'd2;
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 8, 1'b0, {10'h2B4, 4'b1000});
    pulse_clr();
    baud_k = 19'd16;
    repeat (4) @(negedge clk);

    // false start: 4-clock glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    check("glitch_rxrdy", 32'(rxrdy), 32'h0);
    check("glitch_sr", 32'(sr), 32'h2B4);

    // framing error, then overrun with sticky ferr, then clear
    send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 48, 1'b0, {10'h000, 4'b1010});
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1, 48, 1'b0, {10'h302, 4'b1011});
    pulse_clr();
    check("clr_flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);

    // back-to-back frames with a single stop bit
    send_frame(8, 8'h12, 1'b0, 1'b0, 1'b1, 0, 1'b0, {10'h224, 4'b1000});
    send_frame(8, 8'h34, 1'b0, 1'b0, 1'b1, 48, 1'b0, {10'h268, 4'b1001});

    // async reset in the middle of the data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    rx = 1'b1;
    #1;
    check("midreset_sr", 32'(sr), 32'h3FF);
    check("midreset_flags", 32'({rxrdy, perr, ferr, ovf}), 32'h0);
    check("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postreset_sr", 32'(sr), 32'h3FF);
    send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b1, 48, 1'b0, {10'h386, 4'b1000});

    // drain the scoreboard with a bound
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      checks++;
      $display("FAIL missing_frame: expected sr=0x%0h never completed", exp_q[0][13:4]);
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
